// File: rtl/fp_pkg.sv
// Shared format constants and operand class encoding for the FP unpacker.
package fp_pkg;

    localparam int unsigned DP_EXP_W  = 11;
    localparam int unsigned DP_MAN_W  = 52;
    localparam int unsigned SP_EXP_W  = 8;
    localparam int unsigned SP_MAN_W  = 23;

    // Adds to a binary32 exponent field to give the equivalent binary64 field (1023 - 127).
    localparam int unsigned SP_REBIAS = 896;

    typedef enum logic [2:0] {
        FP_NORMAL,
        FP_ZERO,
        FP_SUBNORMAL,
        FP_INF,
        FP_NAN
    } fp_class_e;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fp_lzc #(
    parameter int unsigned W     = 52,
    parameter int unsigned CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     i_data,
    output logic [CNT_W-1:0] o_count_c
);

    // Scan from LSB upward so the most significant set bit wins.
    always_comb begin
        o_count_c = CNT_W'(W);
        for (int i = 0; i < int'(W); i++) begin
            if (i_data[i]) begin
                o_count_c = CNT_W'(int'(W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/floating_point_unpacker.sv
// Two-stage IEEE-754 unpacker: field capture/classify/LZC, then normalise into
// sign, unbiased exponent, explicit-leading-one mantissa and class flags.
module floating_point_unpacker
    import fp_pkg::*;
#(
    parameter  int unsigned EXP_W = 11,
    parameter  int unsigned MAN_W = 52,
    parameter  int unsigned SP_EN = 1,
    localparam int unsigned IN_W  = 1 + EXP_W + MAN_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic                    isFloat,
    input  logic [IN_W-1:0]         in,
    output logic                    outValid,
    input  logic                    outReady,
    output logic                    sign,
    output logic signed [EXP_W:0]   exponent,
    output logic [MAN_W:0]          mantissa,
    output logic                    isZero,
    output logic                    isSubnormal,
    output logic                    isInf,
    output logic                    isNaN,
    output logic                    isSnan
);

    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned LZ_W = $clog2(MAN_W + 1);
    localparam int unsigned EW   = EXP_W + 1;

    logic              w_s1_load, w_s2_load;
    logic              r_v1, r_v2;

    logic              w_is_sp, w_sp_sign, w_sp_exp_zero, w_sp_exp_max;
    logic [MAN_W-1:0]  w_sp_frac;
    logic [EXP_W-1:0]  w_sp_exp_nrm, w_sp_exp_sub;

    logic              w_sign, w_field_zero, w_field_max;
    logic [EXP_W-1:0]  w_exp_nrm, w_exp_sub, w_exp;
    logic [MAN_W-1:0]  w_frac;
    fp_class_e         w_class;
    logic [LZ_W-1:0]   w_lz;

    logic              r1_sign;
    logic [EXP_W-1:0]  r1_exp;
    logic [MAN_W-1:0]  r1_frac;
    fp_class_e         r1_class;
    logic [LZ_W-1:0]   r1_lz;

    logic [LZ_W-1:0]   w_shamt;
    logic [EXP_W:0]    w_exp_base, w_o_exp;
    logic [MAN_W:0]    w_o_man;
    logic [4:0]        w_o_flags;

    logic              r2_sign;
    logic [EXP_W:0]    r2_exp;
    logic [MAN_W:0]    r2_man;
    logic [4:0]        r2_flags;

    // Each stage loads when empty or when its downstream drains this cycle.
    assign w_s2_load = !r_v2 || outReady;
    assign w_s1_load = !r_v1 || w_s2_load;
    assign inReady   = w_s1_load;

    // Binary32 field extraction, rebias and fraction left-alignment.
    if (SP_EN != 0) begin : g_sp
        assign w_is_sp       = isFloat;
        assign w_sp_sign     = in[SP_EXP_W+SP_MAN_W];
        assign w_sp_exp_zero = (in[SP_EXP_W+SP_MAN_W-1:SP_MAN_W] == '0);
        assign w_sp_exp_max  = &in[SP_EXP_W+SP_MAN_W-1:SP_MAN_W];
        assign w_sp_frac     = {in[SP_MAN_W-1:0], {(MAN_W-SP_MAN_W){1'b0}}};
        assign w_sp_exp_nrm  = EXP_W'(in[SP_EXP_W+SP_MAN_W-1:SP_MAN_W]) + EXP_W'(SP_REBIAS);
        // A single subnormal behaves as a double with field 1-127+1023.
        assign w_sp_exp_sub  = EXP_W'(SP_REBIAS + 1);
    end else begin : g_nosp
        assign w_is_sp       = 1'b0;
        assign w_sp_sign     = 1'b0;
        assign w_sp_exp_zero = 1'b0;
        assign w_sp_exp_max  = 1'b0;
        assign w_sp_frac     = '0;
        assign w_sp_exp_nrm  = '0;
        assign w_sp_exp_sub  = '0;
    end

    // Stage 1 format select and classification.
    always_comb begin
        w_sign       = in[IN_W-1];
        w_frac       = in[MAN_W-1:0];
        w_field_zero = (in[IN_W-2 -: EXP_W] == '0);
        w_field_max  = &in[IN_W-2 -: EXP_W];
        w_exp_nrm    = in[IN_W-2 -: EXP_W];
        w_exp_sub    = EXP_W'(1);
        w_class      = FP_NORMAL;
        if (w_is_sp) begin
            w_sign       = w_sp_sign;
            w_frac       = w_sp_frac;
            w_field_zero = w_sp_exp_zero;
            w_field_max  = w_sp_exp_max;
            w_exp_nrm    = w_sp_exp_nrm;
            w_exp_sub    = w_sp_exp_sub;
        end
        if (w_field_max) begin
            w_class = (w_frac == '0) ? FP_INF : FP_NAN;
        end else if (w_field_zero) begin
            w_class = (w_frac == '0) ? FP_ZERO : FP_SUBNORMAL;
        end
        w_exp = (w_class == FP_SUBNORMAL) ? w_exp_sub : w_exp_nrm;
    end

    fp_lzc #(
        .W     (MAN_W),
        .CNT_W (LZ_W)
    ) u_lzc (
        .i_data    (w_frac),
        .o_count_c (w_lz)
    );

    // Stage 1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r1_sign  <= 1'b0;
            r1_exp   <= '0;
            r1_frac  <= '0;
            r1_class <= FP_NORMAL;
            r1_lz    <= '0;
        end else begin
            if (w_s1_load) begin
                r_v1 <= inValid;
            end
            if (w_s1_load && inValid) begin
                r1_sign  <= w_sign;
                r1_exp   <= w_exp;
                r1_frac  <= w_frac;
                r1_class <= w_class;
                r1_lz    <= w_lz;
            end
        end
    end

    // Stage 2 normalisation; flags are {zero, subnormal, inf, nan, snan}.
    always_comb begin
        w_shamt    = r1_lz + LZ_W'(1);
        w_exp_base = {1'b0, r1_exp} - EW'(BIAS);
        w_o_exp    = w_exp_base;
        w_o_man    = {1'b1, r1_frac};
        w_o_flags  = 5'b00000;
        case (r1_class)
            FP_ZERO: begin
                w_o_exp   = '0;
                w_o_man   = '0;
                w_o_flags = 5'b10000;
            end
            FP_SUBNORMAL: begin
                w_o_exp   = w_exp_base - EW'(w_shamt);
                w_o_man   = {1'b1, r1_frac << w_shamt};
                w_o_flags = 5'b01000;
            end
            FP_INF: begin
                w_o_exp   = EW'(BIAS + 1);
                w_o_man   = {1'b1, {MAN_W{1'b0}}};
                w_o_flags = 5'b00100;
            end
            FP_NAN: begin
                w_o_exp   = EW'(BIAS + 1);
                w_o_flags = {4'b0001, !r1_frac[MAN_W-1]};
            end
            default: ;
        endcase
    end

    // Stage 2 register, holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2     <= 1'b0;
            r2_sign  <= 1'b0;
            r2_exp   <= '0;
            r2_man   <= '0;
            r2_flags <= '0;
        end else begin
            if (w_s2_load) begin
                r_v2 <= r_v1;
            end
            if (w_s2_load && r_v1) begin
                r2_sign  <= r1_sign;
                r2_exp   <= w_o_exp;
                r2_man   <= w_o_man;
                r2_flags <= w_o_flags;
            end
        end
    end

    assign outValid    = r_v2;
    assign sign        = r2_sign;
    assign exponent    = r2_exp;
    assign mantissa    = r2_man;
    assign isZero      = r2_flags[4];
    assign isSubnormal = r2_flags[3];
    assign isInf       = r2_flags[2];
    assign isNaN       = r2_flags[1];
    assign isSnan      = r2_flags[0];

endmodule

// File: tb/tb_floating_point_unpacker.sv
// Directed bench for floating_point_unpacker: values, latency, backpressure, reset.
module tb_floating_point_unpacker;

    logic               clk = 1'b0;
    logic               rst, inValid, inReady, isFloat, outValid, outReady;
    logic [63:0]        in;
    logic               sign, isZero, isSubnormal, isInf, isNaN, isSnan;
    logic signed [11:0] exponent;
    logic [52:0]        mantissa;

    int checks = 0;
    int errors = 0;

    // Back-to-back mixed-mode stream: DP 1.0, SP 1.5, DP min subnormal.
    logic [63:0] bb_in  [3] = '{64'h3FF0000000000000, 64'h000000003FC00000, 64'h0000000000000001};
    logic        bb_f   [3] = '{1'b0, 1'b1, 1'b0};
    logic [11:0] bb_e   [3] = '{12'h000, 12'h000, 12'hBCE};
    logic [52:0] bb_m   [3] = '{53'h10000000000000, 53'h18000000000000, 53'h10000000000000};
    logic [4:0]  bb_fl  [3] = '{5'b00000, 5'b00000, 5'b01000};

    int q[$];
    int k_next, drained, occ;
    logic acc, drn;

    always #5 clk = ~clk;

    floating_point_unpacker dut (
        .clk         (clk),
        .rst         (rst),
        .inValid     (inValid),
        .inReady     (inReady),
        .isFloat     (isFloat),
        .in          (in),
        .outValid    (outValid),
        .outReady    (outReady),
        .sign        (sign),
        .exponent    (exponent),
        .mantissa    (mantissa),
        .isZero      (isZero),
        .isSubnormal (isSubnormal),
        .isInf       (isInf),
        .isNaN       (isNaN),
        .isSnan      (isSnan)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic s, input logic [11:0] e,
                             input logic [52:0] m, input logic [4:0] fl);
        check({tag, ".valid"}, 64'(outValid), 64'd1);
        check({tag, ".sign"},  64'(sign), 64'(s));
        check({tag, ".exp"},   {52'd0, exponent}, {52'd0, e});
        check({tag, ".man"},   {11'd0, mantissa}, {11'd0, m});
        check({tag, ".flags"}, {59'd0, isZero, isSubnormal, isInf, isNaN, isSnan}, {59'd0, fl});
    endtask

    // Called just after a rising edge with an empty pipeline and outReady=1.
    task automatic apply(input string tag, input logic [63:0] v, input logic f, input logic s,
                         input logic [11:0] e, input logic [52:0] m, input logic [4:0] fl);
        check({tag, ".inReady"}, 64'(inReady), 64'd1);
        inValid = 1'b1;
        in      = v;
        isFloat = f;
        @(posedge clk); #1;
        inValid = 1'b0;
        in      = '0;
        isFloat = 1'b0;
        check({tag, ".lat1"}, 64'(outValid), 64'd0);
        @(posedge clk); #1;
        check_out(tag, s, e, m, fl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        inValid  = 1'b0;
        isFloat  = 1'b0;
        in       = '0;
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", 64'(outValid), 64'd0);
        check("rst.sign",  64'(sign), 64'd0);
        check("rst.exp",   {52'd0, exponent}, 64'd0);
        check("rst.man",   {11'd0, mantissa}, 64'd0);
        check("rst.flags", {59'd0, isZero, isSubnormal, isInf, isNaN, isSnan}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst.inReady", 64'(inReady), 64'd1);
        check("post_rst.valid",   64'(outValid), 64'd0);

        // Directed binary64 values.
        apply("one",      64'h3FF0000000000000, 1'b0, 1'b0, 12'h000, 53'h10000000000000, 5'b00000);
        apply("min_sub",  64'h0000000000000001, 1'b0, 1'b0, 12'hBCE, 53'h10000000000000, 5'b01000); // -1074
        apply("top_sub",  64'h0008000000000000, 1'b0, 1'b0, 12'hC01, 53'h10000000000000, 5'b01000); // -1023
        apply("neg_inf",  64'hFFF0000000000000, 1'b0, 1'b1, 12'h400, 53'h10000000000000, 5'b00100);
        apply("snan",     64'h7FF0000000000001, 1'b0, 1'b0, 12'h400, 53'h10000000000001, 5'b00011);
        apply("qnan",     64'h7FF8000000000000, 1'b0, 1'b0, 12'h400, 53'h18000000000000, 5'b00010);
        apply("neg_zero", 64'h8000000000000000, 1'b0, 1'b1, 12'h000, 53'h00000000000000, 5'b10000);
        apply("max_norm", 64'h7FEFFFFFFFFFFFFF, 1'b0, 1'b0, 12'h3FF, 53'h1FFFFFFFFFFFFF, 5'b00000);
        apply("neg_two",  64'hC000000000000000, 1'b0, 1'b1, 12'h001, 53'h10000000000000, 5'b00000);

        // Directed binary32 values (upper word must be ignored).
        apply("sp_1p5",     64'h000000003FC00000, 1'b1, 1'b0, 12'h000, 53'h18000000000000, 5'b00000);
        apply("sp_min_sub", 64'h0000000000000001, 1'b1, 1'b0, 12'hF6B, 53'h10000000000000, 5'b01000); // -149
        apply("sp_max_sub", 64'h00000000007FFFFF, 1'b1, 1'b0, 12'hF81, 53'h1FFFFFC0000000, 5'b01000); // -127
        apply("sp_neg_10",  64'h00000000C1200000, 1'b1, 1'b1, 12'h003, 53'h14000000000000, 5'b00000);
        apply("sp_inf_hi",  64'hDEADBEEF7F800000, 1'b1, 1'b0, 12'h400, 53'h10000000000000, 5'b00100);
        apply("sp_snan",    64'h00000000FF800001, 1'b1, 1'b1, 12'h400, 53'h10000020000000, 5'b00011);
        apply("sp_zero_hi", 64'h1234567800000000, 1'b1, 1'b0, 12'h000, 53'h00000000000000, 5'b10000);

        // Back-to-back operands with per-transaction mode switching.
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                inValid = 1'b1;
                in      = bb_in[c];
                isFloat = bb_f[c];
            end else begin
                inValid = 1'b0;
                in      = '0;
                isFloat = 1'b0;
            end
            if (c >= 2) begin
                check_out($sformatf("b2b%0d", c - 2), 1'b0, bb_e[c-2], bb_m[c-2], bb_fl[c-2]);
            end
            @(posedge clk); #1;
        end

        // Backpressure: six operands with outReady low for the first five cycles.
        k_next  = 1;
        drained = 0;
        occ     = 0;
        for (int c = 0; c < 40 && drained < 6; c++) begin
            outReady = (c >= 5);
            if (k_next <= 6) begin
                inValid = 1'b1;
                in      = {1'b0, 11'(1023 + k_next), 52'(k_next)};
            end else begin
                inValid = 1'b0;
                in      = '0;
            end
            isFloat = 1'b0;
            #1;
            check($sformatf("bp%0d.inReady", c), 64'(inReady), 64'((occ < 2) || outReady));
            if (outValid) begin
                check($sformatf("bp%0d.nonempty", c), 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    check($sformatf("bp%0d.exp", c), {52'd0, exponent}, 64'(q[0]));
                    check($sformatf("bp%0d.man", c), {11'd0, mantissa}, {11'd1, 52'(q[0])});
                end
            end
            acc = inValid && inReady;
            drn = outValid && outReady;
            if (drn && q.size() != 0) begin
                void'(q.pop_front());
                drained++;
            end
            if (acc) begin
                q.push_back(k_next);
                k_next++;
            end
            occ = occ + int'(acc) - int'(drn);
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        check("bp.drained",  64'(drained), 64'd6);
        check("bp.accepted", 64'(k_next), 64'd7);
        check("bp.leftover", 64'(q.size()), 64'd0);
        check("bp.empty",    64'(outValid), 64'd0);

        // Reset asserted with both stages full.
        outReady = 1'b0;
        inValid  = 1'b1;
        in       = 64'h3FF0000000000000;
        @(posedge clk); #1;
        in       = 64'h4000000000000000;
        @(posedge clk); #1;
        inValid  = 1'b0;
        in       = '0;
        check("mid.full_valid",   64'(outValid), 64'd1);
        check("mid.full_inReady", 64'(inReady), 64'd0);
        rst = 1'b1;
        #1;
        check("mid.rst_valid", 64'(outValid), 64'd0);
        check("mid.rst_man",   {11'd0, mantissa}, 64'd0);
        check("mid.rst_exp",   {52'd0, exponent}, 64'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        check("mid.after1_valid", 64'(outValid), 64'd0);
        @(posedge clk); #1;
        check("mid.after2_valid", 64'(outValid), 64'd0);
        apply("mid.new", 64'h3FF0000000000000, 1'b0, 1'b0, 12'h000, 53'h10000000000000, 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/floating_point_unpacker.md
# floating_point_unpacker

Pipelined, parametrised IEEE-754 unpacker that turns a packed floating-point word into sign, unbiased exponent, normalised mantissa with explicit leading bit, and class flags. It supersedes the purely combinational splitter at the front of the floating-point square-root datapath. It adds a valid/ready handshake, subnormal normalisation and special-value classification, so the root core receives pre-normalised operands only. An optional binary32 mode widens single-precision inputs to the double-width output format.

## Interface

Parameters:

- EXP_W, 11, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 52, fraction field width; input width IN_W = 1+EXP_W+MAN_W.
- SP_EN, 1, enables binary32 mode via isFloat; legal only with EXP_W=11, MAN_W=52.

Ports (reset is asynchronous and active-high):

- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- inValid, input, 1, in/isFloat valid this cycle.
- inReady, output, 1, block accepts when inValid && inReady.
- isFloat, input, 1, 1 = binary32 in in[31:0], with upper bits ignored; ignored when SP_EN=0.
- in, input, IN_W, packed operand.
- outValid, output, 1, result valid.
- outReady, input, 1, consumer accepts when outValid && outReady.
- sign, output, 1, operand sign.
- exponent, output, EXP_W+1, signed unbiased exponent.
- mantissa, output, MAN_W+1, normalised significand; bit MAN_W is the leading one.
- isZero, isSubnormal, isInf, isNaN, isSnan, output, 1 each, class flags.

## Operation

- Two-stage pipeline. Each stage has a valid register and loads when it is empty or the next stage drains this cycle.
  - inReady = !v1 || !v2 || outReady.
- Stage 1:
  - Captures the fields.
  - In binary32 mode, rebiases the exponent field (e+896 for normal values) and left-aligns the fraction (frac<<29), keeping single-subnormal information.
  - Classifies the operand.
  - Computes the leading-zero count lz of the fraction.
- Stage 2:
  - Normal: exponent = e - bias; mantissa = {1, frac}.
  - Subnormal: mantissa = {1, frac << (lz+1)} truncated to MAN_W+1 bits; exponent = 1 - bias - (lz+1).
    - For binary64 the minimum is -1074; for binary32 mode the minimum is -149.
  - Zero: exponent 0, mantissa 0, isZero set; sign preserved (±0).
  - Inf: exponent = bias+1, mantissa = {1, 0}, isInf set.
  - NaN: exponent = bias+1, mantissa = {1, frac}.
    - isNaN set.
    - isSnan = !frac[MAN_W-1].
- Exactly one of the class flags (isZero/isSubnormal/isInf/isNaN) or none (normal) is set. isSnan implies isNaN.
- isFloat travels with its data; per-transaction mode switching is allowed back-to-back.

## Timing

- Reset: outValid=0; sign, exponent, mantissa and all flags = 0.
  - inReady = 1 from the first cycle after reset deassert.
- Latency: an operand accepted in cycle N is presented with outValid=1 in cycle N+2, provided outReady has been high.
- Throughput: one operand per cycle.
- Outputs are registered and stay stable while outValid && !outReady.
- With outReady low, at most 2 operands are held, after which inReady=0.
- inReady depends combinationally on outReady (one gate). No other input-to-output combinational path exists.
- Simultaneous accept and drain in a full pipeline: both occur in the same cycle with no bubble.
- Reset asserted mid-stream: all valid bits clear asynchronously and in-flight operands are discarded. No partial result appears after reset.

## Structure

- Package fp_pkg:
  - Format constants DP_EXP_W=11, DP_MAN_W=52, SP_EXP_W=8, SP_MAN_W=23.
  - Rebias constant 896.
  - Class enum {FP_NORMAL, FP_ZERO, FP_SUBNORMAL, FP_INF, FP_NAN}, which stage 1 stores internally.
- Sub-module fp_lzc: parametrised combinational leading-zero counter, width MAN_W, output width clog2(MAN_W+1). It is instanced in stage 1.

## Test plan

- 1.0: in=0x3FF0000000000000 (binary64), outReady=1 -> two cycles later sign=0, exponent=0, mantissa=0x10000000000000, no flags.
- Minimum subnormal: in=0x0000000000000001 -> exponent=-1074, mantissa=0x10000000000000, isSubnormal=1.
- Specials:
  - 0xFFF0000000000000 -> sign=1, isInf=1, exponent=1024.
  - 0x7FF0000000000001 -> isNaN=1, isSnan=1.
  - 0x8000000000000000 -> isZero=1, sign=1.
- Binary32 mode: isFloat=1, in[31:0]=0x3FC00000 (1.5) -> exponent=0, mantissa=0x18000000000000. Then 0x00000001 -> exponent=-149, isSubnormal=1.
- Backpressure: stream 6 distinct operands with outReady held low for 5 cycles -> inReady drops after 2 accepts, outputs hold steady. After release, all 6 emerge in order, none lost or duplicated.
- Reset mid-stream: assert rst with both stages valid -> outValid=0 immediately. After release, the first new operand appears two cycles after acceptance.
